p2s_frame_controller: RTL
=========================

// Module: p2s_frame_controller
// PURPOSE
//  Sequences an 8-bit parallel-to-serial shifter into framed, UART-style serial words.
//  Accepts bytes over a valid/ready handshake and paces them at BAUD_DIV clocks per bit.
//  Emits per frame: start bit, DATA_W data bits LSB first, optional parity, 1-2 stop bits.
//  Sits between the byte producer (FIFO/CPU side) and the serial line driver.
// PARAMETERS
//  DATA_W      8  data bits per frame (>=1)
//  BAUD_DIV    16 clocks per serial bit (>=1)
//  PARITY_MODE 0  0=none, 1=even, 2=odd
//  STOP_BITS   1  stop bits per frame (1 or 2)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous reset, active-low
//  in_valid   in   1       producer offers in_data
//  in_data    in   DATA_W  byte to transmit, sampled on handshake only
//  in_ready   out  1       controller can accept a byte this cycle
//  tx_serial  out  1       serial line, idle high
//  busy       out  1       frame in progress (state != IDLE)
//  frame_done out  1       1-cycle pulse on the final clock of the final stop bit
// BEHAVIOUR
//  Reset (async, rst_n low):
//   - State IDLE; tx_serial=1, in_ready=0, busy=0, frame_done=0; all counters cleared.
//   - in_ready rises on the first clk edge after rst_n deasserts.
//  Handshake: transfer iff in_valid && in_ready at a clk edge.
//   - in_data is loaded into the shifter on that edge.
//   - in_valid may drop or in_data change before transfer with no effect.
//  in_ready (registered) is 1 only:
//   - in IDLE, and
//   - on the final clock of the final stop bit (zero-gap back-to-back frames).
//   - It is 0 in every other busy cycle; in_valid then is ignored, not queued.
//  FSM: IDLE -> START -> DATA -> [PARITY if PARITY_MODE!=0] -> STOP -> IDLE, or STOP -> START on handshake.
//   - Each state bit lasts exactly BAUD_DIV clocks.
//   - baud_cnt counts 0..BAUD_DIV-1, width $clog2(BAUD_DIV+1), cleared on every bit boundary.
//   - DATA: bit_cnt 0..DATA_W-1; the shifter shifts right once per bit boundary; tx = shifter lsb.
//   - PARITY: even = XOR of data bits; odd = its inverse. Parity accumulates as bits shift out.
//   - STOP: tx=1 for STOP_BITS*BAUD_DIV clocks.
//  Latency: tx_serial falls to 0 (start bit) on the edge of the accepting handshake.
//  Frame length: (1+DATA_W+(PARITY_MODE!=0)+STOP_BITS)*BAUD_DIV clocks.
//  tx_serial is registered and glitch-free; it changes only on bit boundaries.
//  Reset mid-frame:
//   - tx_serial=1 immediately; the frame is discarded; frame_done is not pulsed.
//   - Next frame starts clean.
//  Illegal parameters (BAUD_DIV<1, STOP_BITS not 1/2, PARITY_MODE>2) are caught by an elaboration-time $error.
// STRUCTURE
//  Package p2s_pkg:
//   - typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} p2s_state_t
//   - constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
//  Sub-module p2s_shift_reg #(DATA_W): ports clk, rst_n, load, shift_en, par_in, ser_out.
//   - Load has priority over shift.
//   - Shift right, zero fill.
//  Top level holds the FSM, baud/bit counters, parity accumulator and handshake logic.
// TESTING (BAUD_DIV=4, DATA_W=8 unless noted)
//  1 Reset: rst_n=0 -> tx=1, in_ready=0, busy=0; release -> in_ready=1 after 1 edge.
//  2 Single byte 0xA5, no parity, 1 stop -> tx per 4-clk bit 0,1,0,1,0,0,1,0,1,1.
//    Frame lasts 40 clks; frame_done pulses once at clk 40.
//  3 Back-to-back 0x00 then 0xFF with in_valid held -> second start bit directly follows
//    first stop; no idle clock; exactly 2 handshakes, 2 frame_done pulses.
//  4 PARITY_MODE=1, byte 0x07 -> parity bit 1; PARITY_MODE=2 -> parity bit 0.
//    Frame = 44 clks.
//  5 rst_n pulsed low during data bit 3 -> tx=1 asynchronously, no frame_done;
//    then 0x3C transmits correctly.
//  6 STOP_BITS=2; in_valid pulsed while busy -> in_ready=0, byte not accepted;
//    stop phase lasts 8 clks.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared types and constants for the framed parallel-to-serial transmitter.
package p2s_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} p2s_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/p2s_shift_reg.sv
// Parallel-load, shift-right (zero fill) register; ser_out is the current lsb.
module p2s_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] par_in,
  output logic              ser_out
);

  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= par_in;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
    end
  end

  assign ser_out = shreg[0];

endmodule

// File: rtl/p2s_frame_controller.sv
// Frames bytes from a valid/ready producer into start/data/parity/stop serial words,
// BAUD_DIV clocks per bit, with zero-gap back-to-back frames.
module p2s_frame_controller
  import p2s_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int BAUD_DIV    = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_serial,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int CW = $clog2(DATA_W + 2);
  localparam logic [BW-1:0] LAST_BAUD = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY_MODE != PAR_NONE);

  generate
    if (BAUD_DIV < 1 || DATA_W < 1 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_param_check
      $error("p2s_frame_controller: illegal parameter combination");
    end
  endgenerate

  p2s_state_t    state, state_next;
  logic [BW-1:0] baud_cnt, baud_next;
  logic [CW-1:0] bit_cnt, bit_next;
  logic          tx_next, load, shift_en, ser_out;
  logic          par_acc, par_bit, handshake, last_baud, final_next;

  assign handshake = in_valid && in_ready;
  assign last_baud = (baud_cnt == LAST_BAUD);
  assign par_bit   = (PARITY_MODE == PAR_ODD) ? ~par_acc : par_acc;
  assign busy      = (state != IDLE);

  p2s_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift_en),
    .par_in   (in_data),
    .ser_out  (ser_out)
  );

  // The shifter advances on the same boundary that drives its lsb onto the line,
  // so ser_out always holds the next bit to emit.
  always_comb begin
    state_next = state;
    baud_next  = last_baud ? '0 : baud_cnt + 1'b1;
    bit_next   = bit_cnt;
    tx_next    = tx_serial;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (handshake) begin
          state_next = START;
          load       = 1'b1;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (last_baud) begin
          state_next = DATA;
          bit_next   = '0;
          tx_next    = ser_out;
          shift_en   = 1'b1;
        end
      end
      DATA: begin
        if (last_baud) begin
          if (bit_cnt == LAST_DATA) begin
            bit_next = '0;
            if (HAS_PARITY) begin
              state_next = PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_cnt + 1'b1;
            tx_next  = ser_out;
            shift_en = 1'b1;
          end
        end
      end
      PARITY: begin
        if (last_baud) begin
          state_next = STOP;
          bit_next   = '0;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (last_baud) begin
          bit_next = '0;
          if (bit_cnt != LAST_STOP) begin
            bit_next = bit_cnt + 1'b1;
          end else if (handshake) begin
            state_next = START;
            load       = 1'b1;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Lookahead: the registered flags must be high during the final stop clock itself.
  assign final_next = (state_next == STOP) && (bit_next == LAST_STOP) && (baud_next == LAST_BAUD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      par_acc    <= 1'b0;
      tx_serial  <= 1'b1;
      in_ready   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      tx_serial  <= tx_next;
      in_ready   <= (state_next == IDLE) || final_next;
      frame_done <= final_next;
      if (load) begin
        par_acc <= 1'b0;
      end else if (shift_en) begin
        par_acc <= par_acc ^ ser_out;
      end
    end
  end

endmodule
